instruction_prefetch: RTL and testbench

- Upstream stage of the instruction byte FIFO that the ModR/M decoder and immediate reader consume.
- Fetches 16-bit words from the memory bus at the physical address formed from CS:IP.
- Splits each word into bytes and pushes them into the FIFO in program order.
- Restarts at a new CS:IP on request, for jumps, calls and interrupts, and flushes the FIFO when it does so.

---
 rtl/instruction_prefetch_if.sv | 25 ++
 rtl/instruction_prefetch.sv | 140 ++++++++++++++
 tb/tb_instruction_prefetch.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_prefetch_if.sv
// Bundles the fetch restart, FIFO write and memory read signals of the prefetch stage.
// The master modport is the prefetcher; the slave modport is its environment.
interface instruction_prefetch_if;
    logic        load_new_ip;
    logic [15:0] new_cs;
    logic [15:0] new_ip;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_full;
    logic        fifo_reset;
    logic        mem_access;
    logic        mem_ack;
    logic [18:0] mem_address;
    logic [15:0] mem_data;

    modport master (
        input  load_new_ip, new_cs, new_ip, fifo_full, mem_ack, mem_data,
        output fifo_wr_en, fifo_wr_data, fifo_reset, mem_access, mem_address
    );

    modport slave (
        output load_new_ip, new_cs, new_ip, fifo_full, mem_ack, mem_data,
        input  fifo_wr_en, fifo_wr_data, fifo_reset, mem_access, mem_address
    );
endinterface

// File: rtl/instruction_prefetch.sv
// Instruction prefetcher: reads 16-bit words at CS:IP and pushes their bytes into the
// instruction FIFO in program order; restarts and flushes the FIFO on load_new_ip.
module instruction_prefetch #(
    parameter logic [15:0] RESET_CS = 16'hffff,
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,
    instruction_prefetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        WRITE_LO = 2'd2,
        WRITE_HI = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] fetch_cs_r;
    logic [15:0] fetch_cs_s;
    logic [15:0] fetch_ip_r;
    logic [15:0] fetch_ip_s;
    logic [15:0] latch_r;
    logic [15:0] latch_s;
    logic        abort_r;
    logic        abort_s;
    logic        fifo_reset_r;
    logic        fifo_reset_s;

    // Word address of CS:IP: (CS*16 + IP) / 2 equals CS*8 + IP[15:1], wrapped to 19 bits.
    function automatic logic [18:0] word_addr(input logic [15:0] seg, input logic [14:0] off_hi);
        return {seg, 3'b000} + {4'b0000, off_hi};
    endfunction

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            fetch_cs_r   <= RESET_CS;
            fetch_ip_r   <= RESET_IP;
            latch_r      <= 16'h0000;
            abort_r      <= 1'b0;
            fifo_reset_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            fetch_cs_r   <= fetch_cs_s;
            fetch_ip_r   <= fetch_ip_s;
            latch_r      <= latch_s;
            abort_r      <= abort_s;
            fifo_reset_r <= fifo_reset_s;
        end
    end

    // Next-state logic; a restart request overrides every state.
    always_comb begin
        state_s      = state_r;
        fetch_cs_s   = fetch_cs_r;
        fetch_ip_s   = fetch_ip_r;
        latch_s      = latch_r;
        abort_s      = abort_r;
        fifo_reset_s = 1'b0;
        if (bus.load_new_ip) begin
            fetch_cs_s   = bus.new_cs;
            fetch_ip_s   = bus.new_ip;
            fifo_reset_s = 1'b1;
            // The bus cannot be cancelled: keep the request up and drop its data later.
            if ((state_r == FETCH) && !bus.mem_ack) begin
                state_s = FETCH;
                abort_s = 1'b1;
            end else begin
                state_s = IDLE;
                abort_s = 1'b0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = FETCH;
                end
                FETCH: begin
                    if (bus.mem_ack) begin
                        if (abort_r) begin
                            abort_s = 1'b0;
                            state_s = IDLE;
                        end else begin
                            latch_s = bus.mem_data;
                            state_s = fetch_ip_r[0] ? WRITE_HI : WRITE_LO;
                        end
                    end else begin
                        state_s = FETCH;
                    end
                end
                WRITE_LO: begin
                    if (!bus.fifo_full) begin
                        fetch_ip_s = fetch_ip_r + 16'd1;
                        state_s    = WRITE_HI;
                    end else begin
                        state_s = WRITE_LO;
                    end
                end
                WRITE_HI: begin
                    if (!bus.fifo_full) begin
                        fetch_ip_s = fetch_ip_r + 16'd1;
                        state_s    = IDLE;
                    end else begin
                        state_s = WRITE_HI;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Output decode; mem_access depends only on the state register.
    always_comb begin
        bus.mem_access   = (state_r == FETCH);
        bus.mem_address  = word_addr(fetch_cs_r, fetch_ip_r[15:1]);
        bus.fifo_reset   = fifo_reset_r;
        bus.fifo_wr_en   = 1'b0;
        bus.fifo_wr_data = 8'h00;
        case (state_r)
            WRITE_LO: begin
                bus.fifo_wr_data = latch_r[7:0];
                bus.fifo_wr_en   = !bus.fifo_full && !bus.load_new_ip;
            end
            WRITE_HI: begin
                bus.fifo_wr_data = latch_r[15:8];
                bus.fifo_wr_en   = !bus.fifo_full && !bus.load_new_ip;
            end
            default: begin
                bus.fifo_wr_data = 8'h00;
                bus.fifo_wr_en   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: memory responder, transaction-level byte/address model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_instruction_prefetch;

    logic clk = 1'b0;
    logic reset = 1'b0;
    instruction_prefetch_if bus();

    instruction_prefetch #(.RESET_CS(16'hffff), .RESET_IP(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory image and responder ----------------
    logic [15:0] mem_over [logic [18:0]];
    int          lat_cfg = 1;
    logic [18:0] resp_req = 19'h0;
    logic        resp_busy = 1'b0;
    int          resp_lat = 0;

    function automatic logic [15:0] word_at(input logic [18:0] a);
        if (mem_over.exists(a)) return mem_over[a];
        return {a[7:0] ^ a[18:11], a[15:8] + 8'h3c};
    endfunction

    initial begin
        bus.mem_ack  = 1'b0;
        bus.mem_data = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            if (!reset || bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                resp_busy   = 1'b0;
            end else begin
                if (!resp_busy && bus.mem_access) begin
                    resp_busy = 1'b1;
                    resp_req  = bus.mem_address;
                    resp_lat  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
                end
                if (resp_busy) begin
                    if (resp_lat == 0) begin
                        bus.mem_ack  = 1'b1;
                        bus.mem_data = word_at(resp_req);
                    end else begin
                        resp_lat--;
                    end
                end
            end
        end
    end

    // ---------------- behavioural model and per-cycle compare ----------------
    logic [7:0]  pend[$];
    logic [7:0]  wr_log[$];
    logic [18:0] req_log[$];
    logic [15:0] m_cs = 16'hffff;
    logic [15:0] m_ip = 16'h0000;
    logic        stale = 1'b0;
    logic        prev_acc = 1'b0;
    logic        prev_ack = 1'b0;
    logic        exp_rst = 1'b0;
    int          wr_total = 0;

    function automatic logic [18:0] model_addr(input logic [15:0] cs, input logic [15:0] ip);
        int phys;
        phys = (int'(cs) * 16 + int'(ip)) % (1 << 20);
        return 19'(phys / 2);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            pend.delete();
            stale    = 1'b0;
            m_cs     = 16'hffff;
            m_ip     = 16'h0000;
            prev_acc = 1'b0;
            prev_ack = 1'b0;
            exp_rst  = 1'b0;
        end else begin
            chk("fifo_reset", bus.fifo_reset, exp_rst);
            if (pend.size() != 0) chk("no_req_while_pending", bus.mem_access, 1'b0);
            if (pend.size() != 0 && !bus.fifo_full && !bus.load_new_ip)
                chk("wr_en_due", bus.fifo_wr_en, 1'b1);
            if (pend.size() == 0 || bus.fifo_full)
                chk("wr_en_quiet", bus.fifo_wr_en, 1'b0);
            if (bus.fifo_wr_en && pend.size() != 0 && !bus.load_new_ip) begin
                chk("wr_data", bus.fifo_wr_data, pend.pop_front());
                wr_log.push_back(bus.fifo_wr_data);
                wr_total++;
                m_ip = m_ip + 16'd1;
            end
            if (prev_acc && !prev_ack) chk("access_held", bus.mem_access, 1'b1);
            if (prev_acc && prev_ack) chk("access_gap", bus.mem_access, 1'b0);
            if (bus.mem_access && !prev_acc) begin
                chk("req_addr", bus.mem_address, model_addr(m_cs, m_ip));
                req_log.push_back(bus.mem_address);
            end
            if (bus.mem_access && bus.mem_ack) begin
                if (bus.load_new_ip || stale) begin
                    stale = 1'b0;
                end else begin
                    if (!m_ip[0]) pend.push_back(bus.mem_data[7:0]);
                    pend.push_back(bus.mem_data[15:8]);
                end
            end
            exp_rst = 1'b0;
            if (bus.load_new_ip) begin
                if (bus.mem_access && !bus.mem_ack) stale = 1'b1;
                pend.delete();
                m_cs    = bus.new_cs;
                m_ip    = bus.new_ip;
                exp_rst = 1'b1;
            end
            prev_acc = bus.mem_access;
            prev_ack = bus.mem_ack;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nsamp();
        @(negedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] cs, input logic [15:0] ip);
        cyc();
        bus.load_new_ip = 1'b1;
        bus.new_cs      = cs;
        bus.new_ip      = ip;
        cyc();
        bus.load_new_ip = 1'b0;
        wr_log.delete();
        req_log.delete();
    endtask

    task automatic wait_bytes(input int n, input string nm);
        for (int i = 0; i < 300; i++) begin
            if (wr_log.size() >= n) break;
            nsamp();
        end
        chk(nm, (wr_log.size() >= n), 1'b1);
    endtask

    task automatic wait_reqs(input int n, input string nm);
        for (int i = 0; i < 300; i++) begin
            if (req_log.size() >= n) break;
            nsamp();
        end
        chk(nm, (req_log.size() >= n), 1'b1);
    endtask

    task automatic wait_ack_for(input logic [18:0] a, input string nm);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            nsamp();
            if (bus.mem_ack && resp_req == a) begin
                found = 1'b1;
                break;
            end
        end
        chk(nm, found, 1'b1);
    endtask

    function automatic logic [8:0] byte_at(input int k);
        return (k < wr_log.size()) ? {1'b0, wr_log[k]} : 9'h1ff;
    endfunction

    function automatic logic [19:0] req_at(input int k);
        return (k < req_log.size()) ? {1'b0, req_log[k]} : 20'hfffff;
    endfunction

    // Releases reset (held low by the caller) and pins the reset state and first request.
    task automatic release_checks(input string p);
        cyc();
        reset = 1'b1;
        wr_log.delete();
        req_log.delete();
        nsamp();
        chk({p, "_access_idle"}, bus.mem_access, 1'b0);
        chk({p, "_addr_idle"}, bus.mem_address, 19'h7fff8);
        chk({p, "_wr_en_idle"}, bus.fifo_wr_en, 1'b0);
        chk({p, "_fifo_reset_idle"}, bus.fifo_reset, 1'b0);
        chk({p, "_wr_data_idle"}, bus.fifo_wr_data, 8'h00);
        nsamp();
        chk({p, "_first_access"}, bus.mem_access, 1'b1);
        chk({p, "_first_addr"}, bus.mem_address, 19'h7fff8);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.load_new_ip = 1'b0;
        bus.new_cs      = 16'h0000;
        bus.new_ip      = 16'h0000;
        bus.fifo_full   = 1'b0;
        mem_over[19'h7fff8] = 16'hEA90;
        mem_over[19'h00080] = 16'hBBAA;
        mem_over[19'h00100] = 16'h3412;
        mem_over[19'h08000] = 16'h5678;
        mem_over[19'h07fff] = 16'h2211;

        // Boot from FFFF:0000
        repeat (3) cyc();
        release_checks("boot");
        wait_bytes(2, "boot_bytes");
        chk("boot_b0", byte_at(0), 9'h090);
        chk("boot_b1", byte_at(1), 9'h0ea);
        wait_reqs(2, "boot_reqs");
        chk("boot_next_req", req_at(1), 20'h7fff9);

        // Odd start: only the high byte is pushed
        do_load(16'h0000, 16'h0101);
        nsamp();
        chk("odd_flush_pulse", bus.fifo_reset, 1'b1);
        wait_bytes(1, "odd_bytes");
        chk("odd_b0", byte_at(0), 9'h0bb);
        wait_reqs(2, "odd_reqs");
        chk("odd_req0", req_at(0), 20'h00080);
        chk("odd_req1", req_at(1), 20'h00081);

        // Backpressure for five cycles right after the ack
        do_load(16'h0000, 16'h0200);
        wait_ack_for(19'h00100, "bp_ack");
        cyc();
        bus.fifo_full = 1'b1;
        wr_log.delete();
        for (int i = 0; i < 5; i++) begin
            nsamp();
            chk("bp_no_write", bus.fifo_wr_en, 1'b0);
            chk("bp_no_access", bus.mem_access, 1'b0);
        end
        cyc();
        bus.fifo_full = 1'b0;
        wait_bytes(2, "bp_bytes");
        chk("bp_b0", byte_at(0), 9'h012);
        chk("bp_b1", byte_at(1), 9'h034);

        // Restart while a slow request is outstanding
        lat_cfg = 4;
        req_log.delete();
        wait_reqs(1, "flush_req_seen");
        mem_over[resp_req] = 16'hDEAD;
        do_load(16'h1000, 16'h0000);
        nsamp();
        chk("flush_pulse", bus.fifo_reset, 1'b1);
        chk("flush_held", bus.mem_access, 1'b1);
        nsamp();
        chk("flush_pulse_end", bus.fifo_reset, 1'b0);
        wait_reqs(1, "flush_reqs");
        chk("flush_new_req", req_at(0), 20'h08000);
        wait_bytes(1, "flush_bytes");
        chk("flush_b0", byte_at(0), 9'h078);
        lat_cfg = 1;

        // IP and physical-address wrap
        do_load(16'h0000, 16'hfffe);
        wait_bytes(2, "wrap_bytes");
        chk("wrap_b0", byte_at(0), 9'h011);
        chk("wrap_b1", byte_at(1), 9'h022);
        wait_reqs(2, "wrap_reqs");
        chk("wrap_req0", req_at(0), 20'h07fff);
        chk("wrap_req1", req_at(1), 20'h00000);
        do_load(16'hffff, 16'h0010);
        wait_reqs(1, "wrap20_reqs");
        chk("wrap20_req", req_at(0), 20'h00000);

        // Reset while stalled in the high-byte write
        do_load(16'h0000, 16'h0301);
        wait_ack_for(19'h00180, "midrst_ack");
        cyc();
        bus.fifo_full = 1'b1;
        nsamp();
        chk("midrst_stall", bus.fifo_wr_en, 1'b0);
        cyc();
        reset = 1'b0;
        bus.fifo_full = 1'b0;
        release_checks("midrst");
        wait_bytes(2, "midrst_bytes");
        chk("midrst_b0", byte_at(0), 9'h090);
        chk("midrst_b1", byte_at(1), 9'h0ea);

        // Random traffic against the model
        lat_cfg = -1;
        base = wr_total;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            bus.fifo_full   = ($urandom_range(0, 3) == 0);
            bus.load_new_ip = ($urandom_range(0, 49) == 0);
            bus.new_cs      = 16'($urandom);
            bus.new_ip      = 16'($urandom);
            reset           = ($urandom_range(0, 599) != 0);
        end
        cyc();
        reset = 1'b1;
        bus.load_new_ip = 1'b0;
        bus.fifo_full = 1'b0;
        repeat (20) cyc();
        chk("random_liveness", ((wr_total - base) > 200), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
